// File: rtl/axi_dma_pkg.sv
// Shared definitions for the axi_dma configuration master: FSM states, AXI
// response codes and the DMA register map offsets used by host software.
package axi_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        RSP    = 3'd5
    } cfg_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [31:0] DMA_EN      = 32'h0000_0000;
    localparam logic [31:0] CHN_EN      = 32'h0000_0001;
    localparam logic [31:0] DESC_SUBMIT = 32'h0000_1000;
    localparam logic [31:0] TRANSFER_ID = 32'h0000_2001;

endpackage

// File: rtl/axi_dma_cfg_master.sv
// Single-outstanding AXI4 register master feeding the axi_dma slave port.
// Optional watchdog enabled by defining AXI_DMA_CFG_TIMEOUT_EN.
module axi_dma_cfg_master
    import axi_dma_pkg::*;
#(
    parameter int MST_ID_W    = 5,
    parameter int S_ADDR_W    = 32,
    parameter int S_DATA_W    = 32,
    parameter int ATX_LEN_W   = 8,
    parameter int ATX_RESP_W  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [S_ADDR_W-1:0]   cmd_addr_i,
    input  logic [S_DATA_W-1:0]   cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [S_DATA_W-1:0]   rsp_rdata_o,
    output logic [ATX_RESP_W-1:0] rsp_resp_o,
    output logic                  rsp_iderr_o,
    output logic [MST_ID_W-1:0]   m_awid_o,
    output logic [S_ADDR_W-1:0]   m_awaddr_o,
    output logic [ATX_LEN_W-1:0]  m_awlen_o,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic [S_DATA_W-1:0]   m_wdata_o,
    output logic                  m_wlast_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    input  logic [MST_ID_W-1:0]   m_bid_i,
    input  logic [ATX_RESP_W-1:0] m_bresp_i,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,
    output logic [MST_ID_W-1:0]   m_arid_o,
    output logic [S_ADDR_W-1:0]   m_araddr_o,
    output logic [ATX_LEN_W-1:0]  m_arlen_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [MST_ID_W-1:0]   m_rid_i,
    input  logic [S_DATA_W-1:0]   m_rdata_i,
    input  logic [ATX_RESP_W-1:0] m_rresp_i,
    input  logic                  m_rlast_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic                  stray_o
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("axi_dma_cfg_master: TIMEOUT_CYC must be at least 2");
    end

    cfg_state_e            state_r;
    logic [MST_ID_W-1:0]   id_cnt_r;
    logic [MST_ID_W-1:0]   id_r;
    logic [S_ADDR_W-1:0]   addr_r;
    logic [S_DATA_W-1:0]   wdata_r;
    logic [S_DATA_W-1:0]   rdata_r;
    logic [ATX_RESP_W-1:0] resp_r;
    logic                  cmd_ready_r;
    logic                  rsp_valid_r;
    logic                  iderr_r;
    logic                  awvalid_r;
    logic                  wvalid_r;
    logic                  arvalid_r;
    logic                  stray_r;

    logic aw_done_s;
    logic w_done_s;
    logic progress_s;
    logic busy_s;
    logic timeout_s;

    assign aw_done_s = !awvalid_r || m_awready_i;
    assign w_done_s  = !wvalid_r  || m_wready_i;

    // Per-state completion event; a watchdog expiry only wins without one.
    always_comb begin
        progress_s = 1'b0;
        busy_s     = 1'b0;
        case (state_r)
            WR_REQ: begin progress_s = aw_done_s && w_done_s; busy_s = 1'b1; end
            WR_RSP: begin progress_s = m_bvalid_i;            busy_s = 1'b1; end
            RD_REQ: begin progress_s = m_arready_i;           busy_s = 1'b1; end
            RD_RSP: begin progress_s = m_rvalid_i;            busy_s = 1'b1; end
            default: begin progress_s = 1'b0;                 busy_s = 1'b0; end
        endcase
    end

`ifdef AXI_DMA_CFG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // Watchdog: counts cycles spent waiting on the slave, cleared otherwise.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (busy_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= {WD_W{1'b0}};
        end
    end

    assign timeout_s = busy_s && (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Main transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r     <= IDLE;
            id_cnt_r    <= {MST_ID_W{1'b0}};
            id_r        <= {MST_ID_W{1'b0}};
            addr_r      <= {S_ADDR_W{1'b0}};
            wdata_r     <= {S_DATA_W{1'b0}};
            rdata_r     <= {S_DATA_W{1'b0}};
            resp_r      <= {ATX_RESP_W{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            iderr_r     <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_r) begin
                        addr_r      <= cmd_addr_i;
                        wdata_r     <= cmd_wdata_i;
                        id_r        <= id_cnt_r;
                        id_cnt_r    <= id_cnt_r + MST_ID_W'(1);
                        cmd_ready_r <= 1'b0;
                        if (cmd_wr_i) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (m_awready_i) awvalid_r <= 1'b0;
                    if (m_wready_i)  wvalid_r  <= 1'b0;
                    if (aw_done_s && w_done_s) state_r <= WR_RSP;
                end
                WR_RSP: begin
                    if (m_bvalid_i) begin
                        resp_r      <= m_bresp_i;
                        rdata_r     <= {S_DATA_W{1'b0}};
                        iderr_r     <= (m_bid_i != id_r);
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (m_arready_i) begin
                        arvalid_r <= 1'b0;
                        state_r   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (m_rvalid_i) begin
                        resp_r      <= m_rresp_i;
                        rdata_r     <= m_rdata_i;
                        // Only single-beat reads are issued, so a missing RLAST is an ID fault.
                        iderr_r     <= (m_rid_i != id_r) || !m_rlast_i;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
            if (timeout_s && !progress_s) begin
                awvalid_r   <= 1'b0;
                wvalid_r    <= 1'b0;
                arvalid_r   <= 1'b0;
                resp_r      <= SLVERR;
                rdata_r     <= {S_DATA_W{1'b0}};
                iderr_r     <= 1'b0;
                rsp_valid_r <= 1'b1;
                state_r     <= RSP;
            end
        end
    end

    // Sticky flag for B/R beats arriving outside their response state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stray_r <= 1'b0;
        end else if ((m_bvalid_i && (state_r != WR_RSP)) ||
                     (m_rvalid_i && (state_r != RD_RSP))) begin
            stray_r <= 1'b1;
        end else begin
            stray_r <= stray_r;
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rdata_r;
    assign rsp_resp_o  = resp_r;
    assign rsp_iderr_o = iderr_r;
    assign m_awid_o    = id_r;
    assign m_awaddr_o  = addr_r;
    assign m_awlen_o   = {ATX_LEN_W{1'b0}};
    assign m_awvalid_o = awvalid_r;
    assign m_wdata_o   = wdata_r;
    assign m_wlast_o   = 1'b1;
    assign m_wvalid_o  = wvalid_r;
    assign m_bready_o  = 1'b1;
    assign m_arid_o    = id_r;
    assign m_araddr_o  = addr_r;
    assign m_arlen_o   = {ATX_LEN_W{1'b0}};
    assign m_arvalid_o = arvalid_r;
    assign m_rready_o  = 1'b1;
    assign stray_o     = stray_r;

endmodule

// File: tb/tb_axi_dma_cfg_master.sv
// Directed self-checking bench for axi_dma_cfg_master; the bench plays the
// AXI slave by hand and checks every response against hand-computed values.
module tb_axi_dma_cfg_master;

    logic        aclk;
    logic        areset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        rsp_iderr_o;
    logic [4:0]  m_awid_o;
    logic [31:0] m_awaddr_o;
    logic [7:0]  m_awlen_o;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_wdata_o;
    logic        m_wlast_o;
    logic        m_wvalid_o;
    logic        m_wready_i;
    logic [4:0]  m_bid_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i;
    logic        m_bready_o;
    logic [4:0]  m_arid_o;
    logic [31:0] m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic [4:0]  m_rid_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rlast_i;
    logic        m_rvalid_i;
    logic        m_rready_o;
    logic        stray_o;

    int n_checks;
    int n_errors;

    axi_dma_cfg_master #(
        .MST_ID_W(5), .S_ADDR_W(32), .S_DATA_W(32),
        .ATX_LEN_W(8), .ATX_RESP_W(2), .TIMEOUT_CYC(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_resp_o(rsp_resp_o), .rsp_iderr_o(rsp_iderr_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
        .m_wready_i(m_wready_i),
        .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
        .m_bready_o(m_bready_o),
        .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
        .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .stray_o(stray_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Write with an always-ready slave answering one cycle after the handshake.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] exp_id, input logic [4:0] bid,
                            input logic [1:0] bresp, input int hold);
        logic exp_iderr;
        exp_iderr = (bid != exp_id);
        check("wr_cmd_ready", cmd_ready_o, 1'b1);
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = addr; cmd_wdata_i = data;
        m_awready_i = 1'b1; m_wready_i = 1'b1; rsp_ready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        check("wr_awvalid_c1", m_awvalid_o, 1'b1);
        check("wr_wvalid_c1", m_wvalid_o, 1'b1);
        check("wr_awid", m_awid_o, exp_id);
        check("wr_awaddr", m_awaddr_o, addr);
        check("wr_wdata", m_wdata_o, data);
        step();
        check("wr_valids_c2", {m_awvalid_o, m_wvalid_o, rsp_valid_o}, 3'b000);
        m_bvalid_i = 1'b1; m_bid_i = bid; m_bresp_i = bresp;
        step();
        m_bvalid_i = 1'b0;
        check("wr_rsp_valid_c3", rsp_valid_o, 1'b1);
        check("wr_rsp_resp", rsp_resp_o, bresp);
        check("wr_rsp_iderr", rsp_iderr_o, exp_iderr);
        check("wr_rsp_rdata", rsp_rdata_o, 32'h0);
        for (int k = 0; k < hold; k++) begin
            step();
            check("wr_hold_valid", rsp_valid_o, 1'b1);
            check("wr_hold_payload", {rsp_resp_o, rsp_iderr_o, rsp_rdata_o},
                  {bresp, exp_iderr, 32'h0});
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("wr_rsp_done", rsp_valid_o, 1'b0);
        check("wr_next_ready", cmd_ready_o, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [4:0] exp_id,
                           input logic [4:0] rid, input logic [31:0] rdata,
                           input logic rlast, input logic exp_iderr);
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = addr; cmd_wdata_i = 32'h0;
        m_arready_i = 1'b1; rsp_ready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        check("rd_arvalid_c1", m_arvalid_o, 1'b1);
        check("rd_arid", m_arid_o, exp_id);
        check("rd_araddr", m_araddr_o, addr);
        check("rd_arlen", m_arlen_o, 8'h0);
        step();
        check("rd_arvalid_c2", m_arvalid_o, 1'b0);
        m_rvalid_i = 1'b1; m_rid_i = rid; m_rdata_i = rdata; m_rresp_i = 2'b00;
        m_rlast_i = rlast;
        step();
        m_rvalid_i = 1'b0;
        check("rd_rsp_valid_c3", rsp_valid_o, 1'b1);
        check("rd_rsp_rdata", rsp_rdata_o, rdata);
        check("rd_rsp_resp", rsp_resp_o, 2'b00);
        check("rd_rsp_iderr", rsp_iderr_o, exp_iderr);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("rd_rsp_done", rsp_valid_o, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        areset = 1'b1;
        cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = 32'h0; cmd_wdata_i = 32'h0;
        rsp_ready_i = 1'b0;
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_arready_i = 1'b0;
        m_bid_i = 5'h0; m_bresp_i = 2'b00; m_bvalid_i = 1'b0;
        m_rid_i = 5'h0; m_rdata_i = 32'h0; m_rresp_i = 2'b00; m_rlast_i = 1'b0;
        m_rvalid_i = 1'b0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_readies", {m_bready_o, m_rready_o, m_wlast_o}, 3'b111);
        check("rst_valids", {m_awvalid_o, m_wvalid_o, m_arvalid_o, rsp_valid_o}, 4'b0000);
        check("rst_misc", {stray_o, rsp_iderr_o, rsp_resp_o, m_awlen_o}, 12'h000);
        areset = 1'b0;
        step();

        // Basic write, ID 0
        do_write(32'h8000_0000, 32'h0000_0001, 5'd0, 5'd0, 2'b00, 0);

        // AW stalled five cycles while W completes at once, ID 1
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 32'h8000_0001;
        cmd_wdata_i = 32'h0000_0005; m_awready_i = 1'b0; m_wready_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        check("stall_c1", {m_awvalid_o, m_wvalid_o, m_awid_o}, {2'b11, 5'd1});
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_aw_held", {m_awvalid_o, m_wvalid_o}, 2'b10);
        end
        m_awready_i = 1'b1;
        step();
        check("stall_aw_done", m_awvalid_o, 1'b0);
        m_bvalid_i = 1'b1; m_bid_i = 5'd1; m_bresp_i = 2'b00;
        step();
        m_bvalid_i = 1'b0;
        check("stall_rsp", {rsp_valid_o, rsp_iderr_o, rsp_resp_o}, 4'b1000);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_one_rsp", rsp_valid_o, 1'b0);
            step();
        end

        // BID mismatch with SLVERR, issued ID 2
        do_write(32'h8000_1000, 32'h0000_00AA, 5'd2, 5'h1F, 2'b10, 0);
        // Read TRANSFER_ID, ID 3, then a read missing RLAST, ID 4
        do_read(32'h8000_2001, 5'd3, 5'd3, 32'h0000_0003, 1'b1, 1'b0);
        do_read(32'h8000_0001, 5'd4, 5'd4, 32'h1234_5678, 1'b0, 1'b1);

        // Stray R while idle
        check("stray_before", stray_o, 1'b0);
        m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
        step();
        m_rvalid_i = 1'b0;
        check("stray_set", stray_o, 1'b1);
        step();
        check("stray_sticky", {stray_o, rsp_valid_o, cmd_ready_o}, 3'b101);

        // Reset in the middle of a write
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 32'h8000_0000;
        cmd_wdata_i = 32'h0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        check("mid_valids_up", {m_awvalid_o, m_wvalid_o}, 2'b11);
        areset = 1'b1;
        #1;
        check("mid_rst_drop", {m_awvalid_o, m_wvalid_o, stray_o, cmd_ready_o}, 4'b0001);
        step();
        areset = 1'b0;
        step();

        // 33 writes: IDs wrap 0..31 then 0; first one holds the response 4 cycles
        for (int i = 0; i < 33; i++) begin
            logic [4:0] id;
            id = 5'(i % 32);
            do_write(32'h8000_0001, 32'(i), id, id, 2'b00, (i == 0) ? 4 : 0);
        end

`ifdef AXI_DMA_CFG_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 32'h8000_0000;
            m_awready_i = 1'b1; m_wready_i = 1'b1;
            step();
            cmd_valid_i = 1'b0;
            while (!rsp_valid_o && waited < 40) begin
                step();
                waited++;
            end
            check("to_rsp_seen", rsp_valid_o, 1'b1);
            check("to_resp", {rsp_resp_o, rsp_rdata_o}, {2'b10, 32'h0});
            check("to_latency", 64'(waited), 64'd16);
            rsp_ready_i = 1'b1;
            step();
            rsp_ready_i = 1'b0;
            m_bvalid_i = 1'b1; m_bid_i = 5'd1;
            step();
            m_bvalid_i = 1'b0;
            check("to_late_b_stray", stray_o, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
